// File: rtl/psram_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package    : PsramArbiterTypes
// Description: Shared types and sizing constants for the PSRAM access arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
package PsramArbiterTypes;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_WR = 2'd1,
        GRANT_RD = 2'd2,
        RELEASE  = 2'd3
    } t_state;

    typedef enum logic {
        WRITER = 1'b0,
        READER = 1'b1
    } t_requester;

    localparam int HOLD_CNT_W       = 8;
    localparam int MAX_HOLD_DEFAULT = 255;

endpackage : PsramArbiterTypes
`default_nettype wire

// File: rtl/psram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : psram_access_arbiter
// Description: Round-robin two-port (writer/reader) PSRAM arbiter with forced
//              release after MAX_HOLD grant cycles.
// Revision   : 1.0 - initial release
// ============================================================================
module psram_access_arbiter
    import PsramArbiterTypes::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int ADDR_W   = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_calib,
    input  logic              wr_rq,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    output logic              wr_ack,
    input  logic              rd_rq,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic              rd_ack,
    output logic              mem_cmd,
    output logic              mem_cmd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic              grant_timeout
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

    t_state                  state_q,   state_d;
    t_requester              last_q,    last_d;
    logic [HOLD_CNT_W-1:0]   hold_q,    hold_d;
    logic                    wr_blk_q,  wr_blk_d;
    logic                    rd_blk_q,  rd_blk_d;
    logic                    timeout_q, timeout_d;
    logic                    wr_ack_q;
    logic                    rd_ack_q;

    logic                    wr_elig;
    logic                    rd_elig;

    assign wr_elig = wr_rq & ~wr_blk_q;
    assign rd_elig = rd_rq & ~rd_blk_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= WRITER;
            hold_q    <= '0;
            wr_blk_q  <= 1'b0;
            rd_blk_q  <= 1'b0;
            timeout_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            wr_blk_q  <= wr_blk_d;
            rd_blk_q  <= rd_blk_d;
            timeout_q <= timeout_d;
            wr_ack_q  <= (state_d == GRANT_WR);
            rd_ack_q  <= (state_d == GRANT_RD);
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = '0;
        timeout_d = 1'b0;
        // A block flag survives only while its request stays high
        wr_blk_d  = wr_blk_q & wr_rq;
        rd_blk_d  = rd_blk_q & rd_rq;
        case (state_q)
            // RELEASE arbitrates like IDLE so the ack-low gap is exactly one cycle
            IDLE, RELEASE: begin
                state_d = IDLE;
                if (init_calib) begin
                    if (wr_elig && (!rd_elig || last_q == READER)) begin
                        state_d = GRANT_WR;
                        last_d  = WRITER;
                    end else if (rd_elig) begin
                        state_d = GRANT_RD;
                        last_d  = READER;
                    end
                end
            end
            GRANT_WR: begin
                if (!wr_rq) begin
                    state_d = RELEASE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                    wr_blk_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GRANT_RD: begin
                if (!rd_rq) begin
                    state_d = RELEASE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                    rd_blk_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_cmd     = 1'b0;
        mem_cmd_en  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state_q)
            GRANT_WR: begin
                mem_cmd     = 1'b1;
                mem_cmd_en  = wr_en;
                mem_addr    = wr_addr;
                mem_wr_data = wr_data;
            end
            GRANT_RD: begin
                mem_cmd_en  = rd_en;
                mem_addr    = rd_addr;
            end
            default: ;
        endcase
    end

    assign wr_ack        = wr_ack_q;
    assign rd_ack        = rd_ack_q;
    assign grant_timeout = timeout_q;

endmodule : psram_access_arbiter
`default_nettype wire
